lc3_mem_addr_seq: RTL and testbench
===================================

Name: lc3_mem_addr_seq

Overview:
- Sequences the LC-3 effective-address datapath (ADDR1MUX/ADDR2MUX adder) for memory-class instructions: LD, LDI, LDR, LEA, ST, STI, STR.
- Drives the adder mux selects and latches the adder result into MAR.
- Runs the memory read/write handshake, including the second access for indirect opcodes, and issues the register-file writeback.
- Sits between the main control FSM (start/done) and the memory interface.

Parameters:
- TIMEOUT_CYCLES, 255: max wait cycles for mem_ready per access; used only with MEM_TIMEOUT_EN.

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset_n  in  1  synchronous active-low reset
- start  in  1  begin instruction; honoured only in IDLE
- IR  in  16  instruction; sampled on accepted start
- ADDR  in  16  adder output
- SR_data  in  16  store data from register file
- mem_rdata  in  16  memory read data
- mem_ready  in  1  memory access complete, sampled while mem_rd/mem_wr high
- ADDR1MUX  out  1  0=PC, 1=base register
- ADDR2MUX  out  2  00=0, 01=sext(IR[5:0]), 10=sext(IR[8:0]), 11=sext(IR[10:0])
- base_sel  out  3  ir_q[8:6]
- sr_sel  out  3  ir_q[11:9]
- mem_addr  out  16  MAR
- mem_wdata  out  16  MDR
- mem_rd, mem_wr  out  1 each  access strobes
- rf_we  out  1  register writeback strobe
- rf_dr  out  3  ir_q[11:9]
- rf_wdata  out  16  MDR
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; illegal opcode or timeout

Behaviour:
- Reset (Reset_n=0 at an edge):
  - state=IDLE; ir_q, MAR, MDR = 0; all strobes, done, err, busy = 0.
  - Aborts any operation in progress; mem_rd/mem_wr drop at that edge.
- Mux selects:
  - Decoded from ir_q only in CALC. ADDR1MUX=1 for LDR/STR, else 0. ADDR2MUX=01 for LDR/STR, 10 for others.
  - ADDR1MUX=0 and ADDR2MUX=00 in all other states.
- IDLE:
  - start=1 latches IR into ir_q.
  - Memory-class opcode -> CALC. Any other opcode -> DONE with err=1.
- CALC:
  - MAR<=ADDR.
  - LEA: MDR<=ADDR -> WB.
  - ST/STR: MDR<=SR_data -> WRITE.
  - LD/LDR/LDI/STI -> READ.
- READ:
  - mem_rd=1 held until mem_ready=1; on that edge MDR<=mem_rdata.
  - LDI/STI first access -> IND; otherwise -> WB.
- IND:
  - Strobes low one cycle; MAR<=MDR; indirect flag set.
  - LDI -> READ.
  - STI -> WRITE with MDR<=SR_data.
- WRITE: mem_wr=1 held until mem_ready=1 -> DONE.
- WB: rf_we=1 for exactly one cycle -> DONE.
- DONE: done=1 for one cycle (err as set) -> IDLE.
- Latency, from the start edge to the done-high cycle, with mem_ready=1 in the first access cycle:
  - LEA 3; ST/STR 3; LD/LDR 4; STI 5; LDI 6.
  - Each extra wait cycle adds 1.
- start while busy: ignored; no queuing.
- mem_ready outside READ/WRITE: ignored.
- Address arithmetic is external and wraps modulo 2^16. The block stores ADDR unchanged.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8+ bit counter clears on entry to READ/WRITE and increments each cycle mem_ready=0.
  - Reaching TIMEOUT_CYCLES drops the strobe and goes to DONE with err=1; no rf_we.
- Undefined: READ/WRITE wait indefinitely; err is asserted only for an illegal opcode.

Decomposition:
- Package lc3_seq_pkg:
  - opcode localparams (LD=0010, LDI=1010, LDR=0110, LEA=1110, ST=0011, STI=1011, STR=0111).
  - ADDR2MUX encoding constants.
  - state enum typedef (IDLE, CALC, READ, IND, WRITE, WB, DONE).
- One sub-module, lc3_mem_decode: combinational map from ir_q[15:12] to is_mem, is_load, is_indirect, use_base, addr2_sel.

Test Plan:
- LD, IR=0x2405, ADDR=0x3006, mem_ready=1 immediately, mem_rdata=0xBEEF -> mem_rd at cycle 2 with mem_addr=0x3006; rf_we cycle 3, rf_dr=2, rf_wdata=0xBEEF; done cycle 4, err=0.
- LDR, IR=0x6283 -> in CALC ADDR1MUX=1, ADDR2MUX=01, base_sel=2; mem_ready delayed 3 cycles -> done cycle 7.
- STI, IR=0xB602; pointer read returns 0x4000; SR_data=0x1234 -> mem_wr with mem_addr=0x4000, mem_wdata=0x1234; done cycle 5; rf_we never high.
- LEA, IR=0xE1FF, ADDR=0x2FFF -> no mem strobes; rf_wdata=0x2FFF; done cycle 3.
- IR=0x1042 (ADD) -> done with err=1 at cycle 1; start pulsed while busy during an LD is ignored.
- Reset_n=0 during READ wait -> next cycle mem_rd=0, busy=0, no done; with MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready stuck low -> done with err=1 after 4 wait cycles.

Source files
------------

// File: rtl/lc3_mem_addr_seq_pkg.sv
// Shared opcodes, ADDR2MUX encodings and FSM state type for the LC-3 memory-class sequencer.
package lc3_seq_pkg;

  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_LEA = 4'b1110;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_STR = 4'b0111;

  localparam logic [1:0] A2_ZERO  = 2'b00;
  localparam logic [1:0] A2_OFF6  = 2'b01;
  localparam logic [1:0] A2_OFF9  = 2'b10;
  localparam logic [1:0] A2_OFF11 = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    READ  = 3'd2,
    IND   = 3'd3,
    WRITE = 3'd4,
    WB    = 3'd5,
    DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/lc3_mem_addr_seq_decode.sv
// Combinational opcode classifier for memory-class LC-3 instructions.
module lc3_mem_decode
  import lc3_seq_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_mem,
  output logic       is_load,
  output logic       is_indirect,
  output logic       use_base,
  output logic [1:0] addr2_sel
);

  // Classify the opcode; anything unlisted is illegal for this block.
  always_comb begin
    is_mem      = 1'b0;
    is_load     = 1'b0;
    is_indirect = 1'b0;
    use_base    = 1'b0;
    addr2_sel   = A2_ZERO;
    case (opcode)
      OP_LD:  begin is_mem = 1'b1; is_load = 1'b1; addr2_sel = A2_OFF9; end
      OP_LDI: begin is_mem = 1'b1; is_load = 1'b1; is_indirect = 1'b1; addr2_sel = A2_OFF9; end
      OP_LDR: begin is_mem = 1'b1; is_load = 1'b1; use_base = 1'b1; addr2_sel = A2_OFF6; end
      OP_LEA: begin is_mem = 1'b1; addr2_sel = A2_OFF9; end
      OP_ST:  begin is_mem = 1'b1; addr2_sel = A2_OFF9; end
      OP_STI: begin is_mem = 1'b1; is_indirect = 1'b1; addr2_sel = A2_OFF9; end
      OP_STR: begin is_mem = 1'b1; use_base = 1'b1; addr2_sel = A2_OFF6; end
      default: begin is_mem = 1'b0; end
    endcase
  end

endmodule

// File: rtl/lc3_mem_addr_seq.sv
// LC-3 effective-address / memory-access sequencer for LD, LDI, LDR, LEA, ST, STI, STR.
// Optional macro MEM_TIMEOUT_EN aborts a READ/WRITE after TIMEOUT_CYCLES cycles without mem_ready.
module lc3_mem_addr_seq
  import lc3_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic [15:0] IR,
  input  logic [15:0] ADDR,
  input  logic [15:0] SR_data,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        ADDR1MUX,
  output logic [1:0]  ADDR2MUX,
  output logic [2:0]  base_sel,
  output logic [2:0]  sr_sel,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        rf_we,
  output logic [2:0]  rf_dr,
  output logic [15:0] rf_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  state_t      state_r, next_s;
  logic [15:6] ir_r;
  logic [15:0] mar_r, mdr_r;
  logic        err_r, ind_r;
  logic [CW-1:0] cnt_r;
  logic [3:0]  op_s;
  logic        is_mem_s, is_load_s, is_ind_s, use_base_s, timeout_s;
  logic [1:0]  addr2_s;
  logic        unused_ir_s;

  assign unused_ir_s = ^IR[5:0];

  // In IDLE the incoming IR decides legality; afterwards the latched copy drives everything.
  assign op_s = (state_r == IDLE) ? IR[15:12] : ir_r[15:12];

  lc3_mem_decode u_decode (
    .opcode      (op_s),
    .is_mem      (is_mem_s),
    .is_load     (is_load_s),
    .is_indirect (is_ind_s),
    .use_base    (use_base_s),
    .addr2_sel   (addr2_s)
  );

  assign timeout_s = TO_EN && (cnt_r == CW'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) state_r <= IDLE;
    else          state_r <= next_s;
  end

  // Next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_s = is_mem_s ? CALC : DONE;
        else       next_s = IDLE;
      end
      CALC: begin
        if (ir_r[15:12] == OP_LEA)   next_s = WB;
        else if (is_load_s || is_ind_s) next_s = READ;
        else                         next_s = WRITE;
      end
      READ: begin
        if (mem_ready)      next_s = (is_ind_s && !ind_r) ? IND : WB;
        else if (timeout_s) next_s = DONE;
        else                next_s = READ;
      end
      IND:   next_s = is_load_s ? READ : WRITE;
      WRITE: begin
        if (mem_ready || timeout_s) next_s = DONE;
        else                        next_s = WRITE;
      end
      WB:      next_s = DONE;
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    ADDR1MUX = 1'b0;
    ADDR2MUX = A2_ZERO;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    rf_we    = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state_r)
      CALC:    begin ADDR1MUX = use_base_s; ADDR2MUX = addr2_s; end
      READ:    mem_rd = 1'b1;
      WRITE:   mem_wr = 1'b1;
      WB:      rf_we  = 1'b1;
      DONE:    begin done = 1'b1; err = err_r; end
      default: mem_rd = 1'b0;
    endcase
  end

  // Instruction, MAR/MDR and status registers.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      ir_r  <= 10'd0;
      mar_r <= 16'd0;
      mdr_r <= 16'd0;
      err_r <= 1'b0;
      ind_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            ir_r  <= IR[15:6];
            ind_r <= 1'b0;
            err_r <= !is_mem_s;
          end
        end
        CALC: begin
          mar_r <= ADDR;
          if (ir_r[15:12] == OP_LEA)          mdr_r <= ADDR;
          else if (!is_load_s && !is_ind_s)   mdr_r <= SR_data;
        end
        READ: begin
          if (mem_ready)      mdr_r <= mem_rdata;
          else if (timeout_s) err_r <= 1'b1;
        end
        IND: begin
          mar_r <= mdr_r;
          ind_r <= 1'b1;
          if (!is_load_s) mdr_r <= SR_data;
        end
        WRITE: begin
          if (!mem_ready && timeout_s) err_r <= 1'b1;
        end
        default: ind_r <= ind_r;
      endcase
    end
  end

  // Wait-cycle counter, cleared whenever not stalled in an access.
  always_ff @(posedge Clk) begin
    if (!Reset_n)
      cnt_r <= '0;
    else if ((state_r == READ || state_r == WRITE) && !mem_ready)
      cnt_r <= cnt_r + CW'(1);
    else
      cnt_r <= '0;
  end

  assign base_sel  = ir_r[8:6];
  assign sr_sel    = ir_r[11:9];
  assign rf_dr     = ir_r[11:9];
  assign mem_addr  = mar_r;
  assign mem_wdata = mdr_r;
  assign rf_wdata  = mdr_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_lc3_mem_addr_seq.sv
// Scoreboard bench: directed instructions push expected events; a negedge monitor pops and compares.
module tb_lc3_mem_addr_seq;

  logic        Clk = 1'b0;
  logic        Reset_n, start, mem_ready;
  logic [15:0] IR, ADDR, SR_data, mem_rdata;
  logic        ADDR1MUX, mem_rd, mem_wr, rf_we, busy, done, err;
  logic [1:0]  ADDR2MUX;
  logic [2:0]  base_sel, sr_sel, rf_dr;
  logic [15:0] mem_addr, mem_wdata, rf_wdata;

  lc3_mem_addr_seq dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .IR(IR), .ADDR(ADDR), .SR_data(SR_data),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX),
    .base_sel(base_sel), .sr_sel(sr_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .rf_we(rf_we), .rf_dr(rf_dr), .rf_wdata(rf_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t0 = 0;
  int wait_cfg = 0;
  int wcnt = 0;
  logic [15:0] mem [logic [15:0]];

  logic [5:0]  q_mux  [$];
  logic [15:0] q_rd   [$];
  logic [34:0] q_wr   [$];
  logic [18:0] q_rf   [$];
  logic [31:0] q_done [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  // Memory responder: asserts mem_ready after wait_cfg stalled cycles of an access.
  always @(posedge Clk) begin
    #1;
    if (mem_rd || mem_wr) begin
      mem_ready = (wcnt >= wait_cfg);
      wcnt++;
    end else begin
      mem_ready = 1'b0;
      wcnt = 0;
    end
    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 16'h0000;
  end

  // Monitor: compare every presented event against the head of its queue.
  always @(negedge Clk) begin
    if (ADDR2MUX != 2'b00) begin
      if (q_mux.size() == 0) chk("unexpected_calc", {ADDR1MUX, ADDR2MUX, base_sel}, 64'hFFFF);
      else chk("calc_mux", {ADDR1MUX, ADDR2MUX, base_sel}, q_mux.pop_front());
    end
    if (mem_rd && mem_ready) begin
      if (q_rd.size() == 0) chk("unexpected_rd", mem_addr, 64'hFFFFF);
      else chk("rd_addr", mem_addr, q_rd.pop_front());
    end
    if (mem_wr && mem_ready) begin
      if (q_wr.size() == 0) chk("unexpected_wr", {sr_sel, mem_addr, mem_wdata}, 64'hFFFFFFFFF);
      else chk("wr_sr_addr_data", {sr_sel, mem_addr, mem_wdata}, q_wr.pop_front());
    end
    if (rf_we) begin
      if (q_rf.size() == 0) chk("unexpected_rf_we", {rf_dr, rf_wdata}, 64'hFFFFF);
      else chk("rf_dr_data", {rf_dr, rf_wdata}, q_rf.pop_front());
    end
    if (done) begin
      if (q_done.size() == 0) chk("unexpected_done", {err, 31'(cyc - t0 + 1)}, 64'hFFFFFFFFF);
      else chk("done_err_latency", {err, 31'(cyc - t0 + 1)}, q_done.pop_front());
    end
  end

  task automatic issue(input logic [15:0] ir, input logic [15:0] addr, input logic [15:0] sr, input int w);
    @(negedge Clk);
    IR = ir; ADDR = addr; SR_data = sr; wait_cfg = w; start = 1'b1;
    @(posedge Clk);
    #1 t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (!busy) break;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    Reset_n = 1'b0; start = 1'b0; IR = 16'h0; ADDR = 16'h0; SR_data = 16'h0;
    mem_ready = 1'b0; mem_rdata = 16'h0;
    mem[16'h3006] = 16'hBEEF;
    mem[16'h5000] = 16'h1111;
    mem[16'h3100] = 16'h4000;
    mem[16'h3200] = 16'h6000;
    mem[16'h6000] = 16'h0042;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset_outputs", {busy, done, err, mem_rd, mem_wr, rf_we, ADDR1MUX, ADDR2MUX}, 64'h0);
    chk("reset_mar_mdr", {mem_addr, mem_wdata}, 64'h0);
    Reset_n = 1'b1;

    // LD R2 -> 0xBEEF
    q_mux.push_back({1'b0, 2'b10, 3'd0}); q_rd.push_back(16'h3006);
    q_rf.push_back({3'd2, 16'hBEEF}); q_done.push_back({1'b0, 31'd4});
    issue(16'h2405, 16'h3006, 16'h0000, 0); wait_idle();

    // LDR with 3 wait cycles
    q_mux.push_back({1'b1, 2'b01, 3'd2}); q_rd.push_back(16'h5000);
    q_rf.push_back({3'd1, 16'h1111}); q_done.push_back({1'b0, 31'd7});
    issue(16'h6283, 16'h5000, 16'h0000, 3); wait_idle();

    // STI via pointer at 0x3100 -> 0x4000
    q_mux.push_back({1'b0, 2'b10, 3'd0}); q_rd.push_back(16'h3100);
    q_wr.push_back({3'd3, 16'h4000, 16'h1234}); q_done.push_back({1'b0, 31'd5});
    issue(16'hB602, 16'h3100, 16'h1234, 0); wait_idle();

    // LEA: no memory traffic
    q_mux.push_back({1'b0, 2'b10, 3'd7});
    q_rf.push_back({3'd0, 16'h2FFF}); q_done.push_back({1'b0, 31'd3});
    issue(16'hE1FF, 16'h2FFF, 16'h0000, 0); wait_idle();

    // ST R5
    q_mux.push_back({1'b0, 2'b10, 3'd0});
    q_wr.push_back({3'd5, 16'h30F0, 16'hCAFE}); q_done.push_back({1'b0, 31'd3});
    issue(16'h3A10, 16'h30F0, 16'hCAFE, 0); wait_idle();

    // STR to top of memory with 2 wait cycles
    q_mux.push_back({1'b1, 2'b01, 3'd2});
    q_wr.push_back({3'd6, 16'hFFFF, 16'h0F0F}); q_done.push_back({1'b0, 31'd5});
    issue(16'h7C81, 16'hFFFF, 16'h0F0F, 2); wait_idle();

    // LDI: two reads
    q_mux.push_back({1'b0, 2'b10, 3'd7}); q_rd.push_back(16'h3200); q_rd.push_back(16'h6000);
    q_rf.push_back({3'd4, 16'h0042}); q_done.push_back({1'b0, 31'd6});
    issue(16'hA9FE, 16'h3200, 16'h0000, 0); wait_idle();

    // Illegal opcode (ADD)
    q_done.push_back({1'b1, 31'd1});
    issue(16'h1042, 16'h0000, 16'h0000, 0); wait_idle();

    // LD with a start pulse while busy that must be ignored
    q_mux.push_back({1'b0, 2'b10, 3'd0}); q_rd.push_back(16'h3006);
    q_rf.push_back({3'd2, 16'hBEEF}); q_done.push_back({1'b0, 31'd6});
    issue(16'h2405, 16'h3006, 16'h0000, 2);
    @(negedge Clk);
    IR = 16'h1042; start = 1'b1;
    @(negedge Clk);
    start = 1'b0; IR = 16'h2405;
    wait_idle();
    repeat (4) @(negedge Clk);

    // Reset during a stalled READ
    q_mux.push_back({1'b0, 2'b10, 3'd0});
    issue(16'h2405, 16'h3006, 16'h0000, 100);
    repeat (3) @(negedge Clk);
    chk("stalled_read", {busy, mem_rd}, 2'b11);
    Reset_n = 1'b0;
    @(negedge Clk);
    chk("abort_rd_busy", {busy, mem_rd, done}, 3'b000);
    chk("abort_mar", mem_addr, 16'h0000);
    Reset_n = 1'b1; wait_cfg = 0;
    repeat (5) @(negedge Clk);

    chk("left_mux", q_mux.size(), 0);
    chk("left_rd", q_rd.size(), 0);
    chk("left_wr", q_wr.size(), 0);
    chk("left_rf", q_rf.size(), 0);
    chk("left_done", q_done.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
